// File: rtl/ef_tmr32_pkg.sv
// ---------------------------------------------------------------------------
// ef_tmr32_pkg
// Shared definitions for the EF_TMR32 fault-conditioning path: FSM state
// encoding and default widths for the filter and event counter.
// ---------------------------------------------------------------------------
package ef_tmr32_pkg;

  localparam int FLT_W_DEF = 8;   // filter length / qualification counter width
  localparam int CNT_W_DEF = 16;  // fault event counter width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

endpackage

// File: rtl/ef_sync2.sv
// ---------------------------------------------------------------------------
// ef_sync2
// Generic two-flop synchroniser for bringing asynchronous levels into the
// clk domain. Both stages clear to 0 on reset.
//
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset
//   d      - asynchronous input
//   q      - synchronised output (two clk of latency)
// ---------------------------------------------------------------------------
module ef_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: flops use non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ef_tmr32_fault_filter.sv
// ---------------------------------------------------------------------------
// ef_tmr32_fault_filter
// Conditions the raw external fault pin for EF_TMR32: synchronise, apply
// polarity, qualify over filt_len+1 consecutive samples, then drive a clean
// registered pwm_fault. Release is either automatic (filt_len+1 inactive
// samples) or by software clr. Also provides a one-cycle entry pulse and a
// saturating count of fault entries.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - filter enable; 0 returns the FSM to IDLE
//   fault_in    - raw asynchronous fault pin
//   polarity    - 1: pin high is a fault, 0: pin low is a fault
//   filt_len    - qualification length (filt_len+1 samples)
//   auto_clr    - 1: automatic release, 0: latched until clr
//   clr         - software clear of a latched fault (ignored while active)
//   cnt_clr     - clear of fault_cnt (wins over a coincident increment)
//   pwm_fault   - qualified fault level to EF_TMR32
//   fault_sync  - synchronised, polarity-corrected sample
//   fault_evt   - one-cycle pulse on each entry into FAULT
//   fault_cnt   - saturating count of FAULT entries
// ---------------------------------------------------------------------------
module ef_tmr32_fault_filter
  import ef_tmr32_pkg::*;
#(
  parameter int FLT_W = FLT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fault_in,
  input  logic             polarity,
  input  logic [FLT_W-1:0] filt_len,
  input  logic             auto_clr,
  input  logic             clr,
  input  logic             cnt_clr,
  output logic             pwm_fault,
  output logic             fault_sync,
  output logic             fault_evt,
  output logic [CNT_W-1:0] fault_cnt
);

  logic             sync_q;
  logic             active;
  state_e           state, state_n;
  logic [FLT_W-1:0] qcnt, qcnt_n;
  logic             enter_fault;

  // The synchroniser runs regardless of en so the sample is already settled
  // by the time the filter is enabled.
  ef_sync2 #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (fault_in),
    .q     (sync_q)
  );

  assign active     = ~(sync_q ^ polarity);
  assign fault_sync = active;

  // Qualification compares the current count before incrementing, so
  // filt_len+1 consecutive samples are needed. Using >= means a lowered
  // filt_len takes effect on the next sample and qcnt never wraps.
  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves it unassigned (which would infer a latch).
  always_comb begin
    state_n     = state;
    qcnt_n      = qcnt;
    enter_fault = 1'b0;
    if (!en) begin
      state_n = ST_IDLE;
      qcnt_n  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_ARMED;
          qcnt_n  = '0;
        end
        ST_ARMED: begin
          if (active) begin
            if (qcnt >= filt_len) begin
              state_n     = ST_FAULT;
              qcnt_n      = '0;
              enter_fault = 1'b1;
            end else begin
              qcnt_n = qcnt + FLT_W'(1);
            end
          end else begin
            qcnt_n = '0;
          end
        end
        ST_FAULT: begin
          if (auto_clr) begin
            // qcnt counts consecutive inactive samples while in FAULT.
            if (active) begin
              qcnt_n = '0;
            end else if (qcnt >= filt_len) begin
              state_n = ST_ARMED;
              qcnt_n  = '0;
            end else begin
              qcnt_n = qcnt + FLT_W'(1);
            end
          end else begin
            qcnt_n = '0;
            if (clr && !active) begin
              state_n = ST_ARMED;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          qcnt_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      qcnt      <= '0;
      pwm_fault <= 1'b0;
      fault_evt <= 1'b0;
      fault_cnt <= '0;
    end else begin
      state     <= state_n;
      qcnt      <= qcnt_n;
      // Registered from next-state so pwm_fault rises on the entry edge
      // and is glitch-free toward the timer.
      pwm_fault <= (state_n == ST_FAULT);
      fault_evt <= enter_fault;
      if (cnt_clr) begin
        fault_cnt <= '0;
      end else if (enter_fault && (fault_cnt != '1)) begin
        fault_cnt <= fault_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ef_tmr32_fault_filter.sv
// ---------------------------------------------------------------------------
// tb_ef_tmr32_fault_filter
// Directed bench for ef_tmr32_fault_filter. A default-width instance and a
// CNT_W=2 instance share all inputs; the narrow one exposes counter
// saturation. Inputs change and outputs are sampled 1 ns after posedge clk.
// ---------------------------------------------------------------------------
module tb_ef_tmr32_fault_filter;
  import ef_tmr32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        fault_in;
  logic        polarity;
  logic [7:0]  filt_len;
  logic        auto_clr;
  logic        clr;
  logic        cnt_clr;

  logic        pwm_fault,  fault_sync,  fault_evt;
  logic [15:0] fault_cnt;
  logic        pwm_fault2, fault_sync2, fault_evt2;
  logic [1:0]  fault_cnt2;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ef_tmr32_fault_filter u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fault_in   (fault_in),
    .polarity   (polarity),
    .filt_len   (filt_len),
    .auto_clr   (auto_clr),
    .clr        (clr),
    .cnt_clr    (cnt_clr),
    .pwm_fault  (pwm_fault),
    .fault_sync (fault_sync),
    .fault_evt  (fault_evt),
    .fault_cnt  (fault_cnt)
  );

  ef_tmr32_fault_filter #(.FLT_W(8), .CNT_W(2)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fault_in   (fault_in),
    .polarity   (polarity),
    .filt_len   (filt_len),
    .auto_clr   (auto_clr),
    .clr        (clr),
    .cnt_clr    (cnt_clr),
    .pwm_fault  (pwm_fault2),
    .fault_sync (fault_sync2),
    .fault_evt  (fault_evt2),
    .fault_cnt  (fault_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic evt_seen;
    logic pwm_seen;

    rst_n    = 1'b0;
    en       = 1'b0;
    fault_in = 1'b0;
    polarity = 1'b1;
    filt_len = 8'd4;
    auto_clr = 1'b1;
    clr      = 1'b0;
    cnt_clr  = 1'b0;

    // Reset state
    #12;
    check("rst_pwm",  32'(pwm_fault),  32'd0);
    check("rst_evt",  32'(fault_evt),  32'd0);
    check("rst_cnt",  32'(fault_cnt),  32'd0);
    check("rst_sync", 32'(fault_sync), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    en = 1'b1;
    step(1);
    check("arm_state", 32'(u_dut.state), 32'(ST_ARMED));

    // Glitch of 3 samples with filt_len=4 is rejected
    fault_in = 1'b1;
    step(3);
    fault_in = 1'b0;
    evt_seen = 1'b0;
    pwm_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      evt_seen |= fault_evt;
      pwm_seen |= pwm_fault;
    end
    check("glitch_pwm", 32'(pwm_seen),  32'd0);
    check("glitch_evt", 32'(evt_seen),  32'd0);
    check("glitch_cnt", 32'(fault_cnt), 32'd0);

    // Steady fault: rises on 7th edge, releases 7 edges after drop
    fault_in = 1'b1;
    step(6);
    check("qual_pre",  32'(pwm_fault), 32'd0);
    step(1);
    check("qual_pwm",  32'(pwm_fault), 32'd1);
    check("qual_evt",  32'(fault_evt), 32'd1);
    check("qual_cnt",  32'(fault_cnt), 32'd1);
    step(1);
    check("qual_evt_end", 32'(fault_evt), 32'd0);
    step(12);
    check("qual_hold", 32'(pwm_fault), 32'd1);
    fault_in = 1'b0;
    step(6);
    check("rel_pre",   32'(pwm_fault), 32'd1);
    step(1);
    check("rel_pwm",   32'(pwm_fault), 32'd0);

    // Latched mode, filt_len=0
    auto_clr = 1'b0;
    filt_len = 8'd0;
    fault_in = 1'b1;
    step(3);
    check("latch_pwm", 32'(pwm_fault), 32'd1);
    check("latch_cnt", 32'(fault_cnt), 32'd2);
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_active_ignored", 32'(pwm_fault), 32'd1);
    fault_in = 1'b0;
    step(3);
    check("latch_hold", 32'(pwm_fault), 32'd1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_pwm",   32'(pwm_fault), 32'd0);
    check("clr_state", 32'(u_dut.state), 32'(ST_ARMED));

    // Active-low polarity, filt_len=2
    en       = 1'b0;
    fault_in = 1'b1;
    step(3);
    polarity = 1'b0;
    filt_len = 8'd2;
    #1;
    check("pol0_sync", 32'(fault_sync), 32'd0);
    en = 1'b1;
    step(1);
    fault_in = 1'b0;
    step(4);
    check("pol0_pre", 32'(pwm_fault), 32'd0);
    step(1);
    check("pol0_pwm", 32'(pwm_fault), 32'd1);
    check("pol0_cnt", 32'(fault_cnt), 32'd3);
    en = 1'b0;
    step(1);
    check("dis_pwm",   32'(pwm_fault), 32'd0);
    check("dis_state", 32'(u_dut.state), 32'(ST_IDLE));
    check("dis_cnt",   32'(fault_cnt), 32'd3);

    // Counter clear and saturation (narrow instance)
    polarity = 1'b1;
    filt_len = 8'd0;
    auto_clr = 1'b1;
    cnt_clr  = 1'b1;
    step(1);
    cnt_clr  = 1'b0;
    check("cntclr",  32'(fault_cnt),  32'd0);
    check("cntclr2", 32'(fault_cnt2), 32'd0);
    step(2);
    en = 1'b1;
    step(1);
    for (int i = 0; i < 5; i++) begin
      fault_in = 1'b1;
      step(3);
      fault_in = 1'b0;
      step(3);
    end
    check("sat_cnt2", 32'(fault_cnt2), 32'd3);
    check("sat_cnt",  32'(fault_cnt),  32'd5);
    fault_in = 1'b1;
    step(2);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    check("clrwin_pwm",  32'(pwm_fault2), 32'd1);
    check("clrwin_evt",  32'(fault_evt2), 32'd1);
    check("clrwin_cnt2", 32'(fault_cnt2), 32'd0);
    check("clrwin_cnt",  32'(fault_cnt),  32'd0);

    // Asynchronous reset while in FAULT (first bump the count to 1)
    fault_in = 1'b0;
    step(3);
    fault_in = 1'b1;
    step(3);
    check("pre_rst_cnt", 32'(fault_cnt), 32'd1);
    check("pre_rst_evt", 32'(fault_evt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pwm", 32'(pwm_fault), 32'd0);
    check("arst_cnt", 32'(fault_cnt), 32'd0);
    check("arst_evt", 32'(fault_evt), 32'd0);
    fault_in = 1'b0;
    en       = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    en = 1'b1;
    step(1);
    check("rearm_state", 32'(u_dut.state), 32'(ST_ARMED));
    step(5);
    check("rearm_pwm", 32'(pwm_fault), 32'd0);
    check("rearm_cnt", 32'(fault_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
